// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, with all pins oversampled in the clk domain.
// Traffic reaches the core as parallel words: a 1-entry valid/ready TX buffer and a pulsed RX word.
module spi_slave_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = {DATA_WIDTH{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_mosi,
    input  logic                  i_cs_n,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_rx_abort,
    output logic                  o_tx_underrun,
    output logic                  o_busy
);
    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_rst_pipe;
    logic                    w_rst_n;
    logic                    r_sclk_meta, r_sclk_sync, r_sclk_dly;
    logic                    r_cs_meta, r_cs_sync, r_cs_dly;
    logic                    r_mosi_meta, r_mosi_sync;
    logic                    w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic                    w_in_shift, w_bit_rise, w_bit_fall, w_word_done;
    logic                    w_load, w_handshake;
    logic [DATA_WIDTH-1:0]   w_rx_word;
    logic [DATA_WIDTH-1:0]   r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data;
    logic                    r_tx_full, r_reload;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_rx_valid, r_rx_abort, r_tx_underrun;

    // Reset asserts asynchronously everywhere but is released on a clk edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_pipe <= 2'b00;
        end else begin
            r_rst_pipe <= {r_rst_pipe[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_pipe[1];

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_dly  <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_dly    <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_dly  <= r_sclk_sync;
            r_cs_meta   <= i_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_cs_dly    <= r_cs_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_dly;
    assign w_sclk_fall = ~r_sclk_sync & r_sclk_dly;
    assign w_cs_fall   = ~r_cs_sync & r_cs_dly;
    assign w_cs_rise   = r_cs_sync & ~r_cs_dly;

    // A deselect on the same cycle as an sclk edge takes priority over that edge.
    assign w_in_shift  = (r_state == S_SHIFT);
    assign w_bit_rise  = w_in_shift & w_sclk_rise & ~w_cs_rise;
    assign w_bit_fall  = w_in_shift & w_sclk_fall & ~w_cs_rise;
    assign w_word_done = w_bit_rise & (r_bit_cnt == LAST_BIT);
    assign w_rx_word   = {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync};
    assign w_load      = (~w_in_shift & w_cs_fall) | (w_bit_fall & r_reload);
    assign w_handshake = i_tx_valid & ~r_tx_full;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cs_fall) w_state_next = S_SHIFT;
            S_SHIFT: if (w_cs_rise) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = 1'b0;
        o_miso_oe = 1'b0;
        o_miso    = 1'b0;
        if (r_state == S_SHIFT) begin
            o_busy    = 1'b1;
            o_miso_oe = 1'b1;
            o_miso    = r_tx_shift[DATA_WIDTH-1];
        end
    end

    // Loads see the buffer as it was at the start of the cycle; a same-cycle
    // handshake only refills the buffer for the following word.
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_load) begin
                if (r_tx_full) begin
                    r_tx_shift <= r_tx_buf;
                    r_tx_full  <= 1'b0;
                end else begin
                    r_tx_shift    <= DEFAULT_TX;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_bit_fall) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_handshake) begin
                r_tx_buf  <= i_tx_data;
                r_tx_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_abort <= 1'b0;
            r_bit_cnt  <= '0;
            r_reload   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_abort <= 1'b0;
            if (w_in_shift & w_cs_rise) begin
                r_bit_cnt  <= '0;
                r_reload   <= 1'b0;
                r_rx_abort <= (r_bit_cnt != '0);
            end else if (~w_in_shift & w_cs_fall) begin
                r_bit_cnt <= '0;
                r_reload  <= 1'b0;
            end else begin
                if (w_bit_rise) begin
                    r_rx_shift <= w_rx_word;
                    if (w_word_done) begin
                        r_rx_data  <= w_rx_word;
                        r_rx_valid <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_reload   <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                if (w_bit_fall & r_reload) begin
                    r_reload <= 1'b0;
                end
            end
        end
    end

    assign o_tx_ready    = ~r_tx_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_rx_abort    = r_rx_abort;
    assign o_tx_underrun = r_tx_underrun;

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0), MSB-first. It is the slave end of the SPI link: it samples `sclk`/`mosi`/`cs_n` driven by the master and drives `miso` back.
- All pins are oversampled in the system `clk` domain.
- It presents the SPI traffic to the core as parallel words: a valid/ready port for TX and a one-cycle `rx_valid` pulse for RX.
- It sits behind the bench SPI interface's slave-side signals.

Parameters:
- DATA_WIDTH, 8, bits per SPI word (≥2).
- DEFAULT_TX, 8'hFF (DATA_WIDTH bits), word shifted out when no TX word is buffered.

Ports:
- clk  in  1  system clock; must be ≥8× the sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from the master, asynchronous to `clk`.
- mosi  in  1  serial data from the master.
- cs_n  in  1  chip select from the master, active low.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for `miso`; 1 while selected.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  `tx_data` is valid.
- tx_ready  out  1  the 1-entry TX holding buffer is empty.
- rx_data  out  DATA_WIDTH  last fully received word.
- rx_valid  out  1  one-cycle pulse: `rx_data` has been updated.
- rx_abort  out  1  one-cycle pulse: `cs_n` rose in the middle of a word.
- tx_underrun  out  1  one-cycle pulse: `DEFAULT_TX` was loaded.
- busy  out  1  state is SHIFT.

Behaviour:
- **Reset values:** `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `rx_abort`=0, `tx_underrun`=0, `busy`=0, `tx_ready`=1. Reset clears the TX buffer, shift registers and bit counter. Async assert, release sync to `clk`.
- **Synchronisers:** `sclk`, `mosi` and `cs_n` each pass through a 2-flop synchroniser, then one more register used for edge detection.
- **Edge-detect latency:** pin edge → internal edge strobe is 3 clk cycles.
- **Internal strobes:** sclk_rise, sclk_fall, cs_fall, cs_rise.
- **FSM states:** IDLE and SHIFT.
- **IDLE:**
  - `miso_oe`=0, `miso`=0.
  - On cs_fall: load the TX shift register, clear bit_cnt, go to SHIFT.
  - In SHIFT, `miso_oe`=1 and `miso`=tx_shift[MSB] from the cycle after cs_fall onward.
- **SHIFT:**
  - On sclk_rise: rx_shift ← {rx_shift[DATA_WIDTH-2:0], mosi_sync}; bit_cnt++.
  - When bit_cnt reaches DATA_WIDTH-1 on that rise, the word completes:
    - `rx_data` ← the completed word;
    - `rx_valid`=1 on the next cycle;
    - bit_cnt → 0;
    - a `reload` flag is set.
  - On sclk_fall with `reload` set: load the TX shift register (next word), clear `reload`.
  - On sclk_fall otherwise: tx_shift shifts left by 1, filling with 0.
  - Back-to-back words continue with no gap while `cs_n` stays low.
- **TX load rule:**
  - If the TX buffer is full: tx_shift ← buffer, buffer empties.
  - Otherwise: tx_shift ← DEFAULT_TX, with a `tx_underrun` pulse.
  - The load sees the buffer state at the start of the cycle. A handshake in the same cycle fills the buffer for the next word only; there is no bypass.
- **TX handshake:** a transfer happens when tx_valid && tx_ready. `tx_ready` = buffer empty, registered. The buffer empties in the load cycle, so `tx_ready` is 1 from the following cycle.
- **cs_rise (any state):**
  - Go to IDLE; `miso_oe`=0 on the next cycle; bit_cnt and `reload` clear.
  - If bit_cnt≠0: pulse `rx_abort`, leave `rx_data` unchanged, no `rx_valid`.
  - The TX buffer contents are retained.
- **Simultaneous cs_rise and sclk_rise:** cs_rise wins; that sclk edge is ignored.
- **No RX backpressure:** `rx_data` is overwritten by the next word. A consumer that misses a pulse loses the word.
- **Glitch filter:** sclk edges while in IDLE are ignored.
- **Reset mid-word:** everything returns to reset values immediately; no pulses are generated.

Test Plan:
1. **Single word:** preload tx_data=8'hA5; cs_n low; master sends 8'h3C, sclk = clk/10.
   - Master receives 8'hA5.
   - rx_valid pulses once with rx_data=8'h3C.
   - tx_underrun stays 0.
2. **Back-to-back:** buffer 8'h11, then 8'h22 loaded while word 1 shifts; master sends 8'hC3, 8'h5A under one cs_n.
   - Master receives 11, 22.
   - rx_valid pulses twice, with rx_data=C3 then 5A.
3. **Underrun:** empty buffer; 8-bit transfer.
   - Master receives 8'hFF.
   - tx_underrun pulses once, 1 cycle after cs_fall.
4. **Abort:** cs_n rises after 5 sclk edges of 8'h96.
   - rx_abort pulses once; rx_valid stays 0; rx_data keeps its prior value.
   - miso_oe=0 within 4 clk of the cs_n pin rising.
   - The next full transfer works correctly.
5. **Reset mid-word:** rst_n low after 3 bits.
   - All outputs are at reset values in the same cycle; tx_ready=1.
   - After release, a 8'h7E transfer receives correctly.
6. **Handshake/load collision:** tx_valid rises in the exact cs_fall load cycle with the buffer empty.
   - Word 1 sends DEFAULT_TX with tx_underrun=1.
   - Word 2 sends tx_data.
   - tx_ready goes 0 then returns to 1 after the word-2 load.
